// File: rtl/ctrl_pkg.sv
// Shared control-bundle types, opcode map and ALU operation encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ctrl_pkg;

    // Opcode map; R-type occupies the three codes OP_R1..OP_R3
    localparam int unsigned OP_NOP  = 0;
    localparam int unsigned OP_R1   = 1;
    localparam int unsigned OP_R2   = 2;
    localparam int unsigned OP_R3   = 3;
    localparam int unsigned OP_LUI  = 4;
    localparam int unsigned OP_ADDI = 5;
    localparam int unsigned OP_LW   = 6;
    localparam int unsigned OP_SW   = 7;
    localparam int unsigned OP_JMP  = 8;
    localparam int unsigned OP_BEQ  = 9;
    localparam int unsigned OP_BNE  = 10;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_LUI  = 2'd1;
    localparam logic [1:0] ALU_FUNC = 2'd2;
    localparam logic [1:0] ALU_NOP  = 2'd3;

    // Control bundle carried into EX; RegDst is consumed at ID to pick the dest
    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

    // Subset still needed once the instruction has left EX
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    localparam ctrl_t NOP_BUNDLE = '{
        alu_op:     ALU_NOP,
        alu_src:    1'b0,
        branch:     1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        reg_write:  1'b0,
        mem_to_reg: 1'b0
    };

endpackage

// File: rtl/ctrl_decode.sv
// Opcode to control bundle decode, plus which source registers the op reads.
// Latency: purely combinational.
// Backpressure: none; output follows the opcode every cycle.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] opcode,
    output ctrl_t          ctrl,
    output logic           reg_dst,
    output logic           uses_rs,
    output logic           uses_rt
);

    logic [31:0] op_ext;
    assign op_ext = 32'(opcode);

    // Undefined and out-of-range opcodes fall through to the nop bundle
    always_comb begin
        ctrl    = NOP_BUNDLE;
        reg_dst = 1'b0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        case (op_ext)
            OP_R1, OP_R2, OP_R3: begin
                ctrl.alu_op    = ALU_FUNC;
                ctrl.reg_write = 1'b1;
                reg_dst        = 1'b1;
                uses_rs        = 1'b1;
                uses_rt        = 1'b1;
            end
            OP_LUI: begin
                ctrl.alu_op    = ALU_LUI;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_ADDI: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                uses_rs        = 1'b1;
            end
            OP_LW: begin
                ctrl.alu_op     = ALU_ADD;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                uses_rs         = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                uses_rs        = 1'b1;
                uses_rt        = 1'b1;
            end
            OP_JMP: begin
                ctrl.alu_op = ALU_ADD;
                ctrl.branch = 1'b1;
                uses_rs     = 1'b1;
            end
            OP_BEQ: begin
                ctrl.alu_op = ALU_ADD;
                ctrl.branch = 1'b1;
                uses_rs     = 1'b1;
                uses_rt     = 1'b1;
            end
            OP_BNE: begin
                ctrl.alu_op = ALU_LUI;
                ctrl.branch = 1'b1;
                uses_rs     = 1'b1;
                uses_rt     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control: ID decode carried through ID/EX, EX/MEM, MEM/WB registers.
// Latency: Ex* one edge after ID, Mem* two edges, Wb* three edges.
// Backpressure: HazardStall asks fetch/decode to hold for one cycle on load-use; downstream never stalls.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int OPW       = 6,
    parameter int REGW      = 5,
    parameter int HAZARD_EN = 1
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [OPW-1:0]  Opcode,
    input  logic [REGW-1:0] Rs,
    input  logic [REGW-1:0] Rt,
    input  logic [REGW-1:0] Rd,
    input  logic            Flush,
    output logic            HazardStall,
    output logic [1:0]      ExALUOp,
    output logic            ExALUSrc,
    output logic            ExBranch,
    output logic [REGW-1:0] ExDest,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            WbRegWrite,
    output logic            WbMemtoReg,
    output logic [REGW-1:0] WbDest
);

    ctrl_t           id_ctrl;
    logic            id_reg_dst;
    logic            id_uses_rs;
    logic            id_uses_rt;
    logic [REGW-1:0] id_dest;

    ctrl_t           ex_q;
    logic [REGW-1:0] ex_dest_q;
    mem_ctrl_t       mem_q;
    logic [REGW-1:0] mem_dest_q;
    wb_ctrl_t        wb_q;
    logic [REGW-1:0] wb_dest_q;

    logic            load_use;

    ctrl_decode #(.OPW(OPW)) u_decode (
        .opcode  (Opcode),
        .ctrl    (id_ctrl),
        .reg_dst (id_reg_dst),
        .uses_rs (id_uses_rs),
        .uses_rt (id_uses_rt)
    );

    assign id_dest = id_reg_dst ? Rd : Rt;

    // A load in EX whose result the ID instruction reads; r0 is never a real dependency
    always_comb begin
        load_use = ex_q.mem_read && ex_q.reg_write && (ex_dest_q != '0) &&
                   ((id_uses_rs && (Rs == ex_dest_q)) || (id_uses_rt && (Rt == ex_dest_q)));
    end

    assign HazardStall = (HAZARD_EN != 0) && load_use;

    // ID/EX: flush beats stall; both insert a nop with a zero destination
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ex_q      <= NOP_BUNDLE;
            ex_dest_q <= '0;
        end else if (Flush || HazardStall) begin
            ex_q      <= NOP_BUNDLE;
            ex_dest_q <= '0;
        end else begin
            ex_q      <= id_ctrl;
            ex_dest_q <= id_dest;
        end
    end

    // EX/MEM and MEM/WB advance every cycle regardless of stalls upstream
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mem_q      <= '0;
            mem_dest_q <= '0;
            wb_q       <= '0;
            wb_dest_q  <= '0;
        end else begin
            mem_q.mem_read   <= ex_q.mem_read;
            mem_q.mem_write  <= ex_q.mem_write;
            mem_q.reg_write  <= ex_q.reg_write;
            mem_q.mem_to_reg <= ex_q.mem_to_reg;
            mem_dest_q       <= ex_dest_q;
            wb_q.reg_write   <= mem_q.reg_write;
            wb_q.mem_to_reg  <= mem_q.mem_to_reg;
            wb_dest_q        <= mem_dest_q;
        end
    end

    assign ExALUOp    = ex_q.alu_op;
    assign ExALUSrc   = ex_q.alu_src;
    assign ExBranch   = ex_q.branch;
    assign ExDest     = ex_dest_q;
    assign MemRead    = mem_q.mem_read;
    assign MemWrite   = mem_q.mem_write;
    assign WbRegWrite = wb_q.reg_write;
    assign WbMemtoReg = wb_q.mem_to_reg;
    assign WbDest     = wb_dest_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed scoreboard bench for ctrl_pipe_unit, with a second HAZARD_EN=0 instance.
// Latency: each row's expectation is checked at the falling edge of the cycle it is driven.
// Backpressure: n/a.
module tb_ctrl_pipe_unit;

    logic       Clk;
    logic       Reset;
    logic [5:0] Opcode;
    logic [4:0] Rs, Rt, Rd;
    logic       Flush;

    logic       HazardStall, ExALUSrc, ExBranch, MemRead, MemWrite, WbRegWrite, WbMemtoReg;
    logic [1:0] ExALUOp;
    logic [4:0] ExDest, WbDest;

    logic       HazardStall2, ExALUSrc2, ExBranch2, MemRead2, MemWrite2, WbRegWrite2, WbMemtoReg2;
    logic [1:0] ExALUOp2;
    logic [4:0] ExDest2, WbDest2;

    ctrl_pipe_unit #(.OPW(6), .REGW(5), .HAZARD_EN(1)) u_dut (
        .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Flush(Flush),
        .HazardStall(HazardStall), .ExALUOp(ExALUOp), .ExALUSrc(ExALUSrc), .ExBranch(ExBranch),
        .ExDest(ExDest), .MemRead(MemRead), .MemWrite(MemWrite), .WbRegWrite(WbRegWrite),
        .WbMemtoReg(WbMemtoReg), .WbDest(WbDest)
    );

    ctrl_pipe_unit #(.OPW(6), .REGW(5), .HAZARD_EN(0)) u_nohaz (
        .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Flush(Flush),
        .HazardStall(HazardStall2), .ExALUOp(ExALUOp2), .ExALUSrc(ExALUSrc2), .ExBranch(ExBranch2),
        .ExDest(ExDest2), .MemRead(MemRead2), .MemWrite(MemWrite2), .WbRegWrite(WbRegWrite2),
        .WbMemtoReg(WbMemtoReg2), .WbDest(WbDest2)
    );

    typedef struct packed {
        logic       rst;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       fl;
    } stim_t;

    typedef struct packed {
        logic       st;
        logic [1:0] alu;
        logic       src;
        logic       br;
        logic [4:0] exd;
        logic       mr;
        logic       mw;
        logic       rw;
        logic       m2r;
        logic [4:0] wbd;
    } exp_t;

    stim_t plan_s[$];
    exp_t  plan_e[$];
    exp_t  sb_q[$];

    int checks = 0;
    int errors = 0;
    int mon_row = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic row(input logic rst, input int op, input int rs, input int rt, input int rd,
                       input logic fl, input logic st, input int alu, input logic src,
                       input logic br, input int exd, input logic mr, input logic mw,
                       input logic rw, input logic m2r, input int wbd);
        stim_t s;
        exp_t  e;
        s.rst = rst;  s.op = 6'(op);  s.rs = 5'(rs);  s.rt = 5'(rt);  s.rd = 5'(rd);  s.fl = fl;
        e.st = st;  e.alu = 2'(alu);  e.src = src;  e.br = br;  e.exd = 5'(exd);
        e.mr = mr;  e.mw = mw;  e.rw = rw;  e.m2r = m2r;  e.wbd = 5'(wbd);
        plan_s.push_back(s);
        plan_e.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s row %0d got %0d expected %0d", nm, mon_row, act, exp_v);
        end
    endtask

    // Monitor: every falling edge presents one cycle of outputs to compare
    always @(negedge Clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("HazardStall",      int'(HazardStall),  int'(e.st));
            chk("ExALUOp",          int'(ExALUOp),      int'(e.alu));
            chk("ExALUSrc",         int'(ExALUSrc),     int'(e.src));
            chk("ExBranch",         int'(ExBranch),     int'(e.br));
            chk("ExDest",           int'(ExDest),       int'(e.exd));
            chk("MemRead",          int'(MemRead),      int'(e.mr));
            chk("MemWrite",         int'(MemWrite),     int'(e.mw));
            chk("WbRegWrite",       int'(WbRegWrite),   int'(e.rw));
            chk("WbMemtoReg",       int'(WbMemtoReg),   int'(e.m2r));
            chk("WbDest",           int'(WbDest),       int'(e.wbd));
            chk("HazardStall_noen", int'(HazardStall2), 0);
            mon_row++;
        end
    end

    initial begin
        Reset  = 1'b1;
        Opcode = '0;
        Rs     = '0;
        Rt     = '0;
        Rd     = '0;
        Flush  = 1'b0;

        //    rst op  rs rt rd fl | st alu src br exd mr mw rw m2r wbd
        // reset held, then released with nops
        row(1,  0,  0, 0, 0, 0,   0, 3, 0, 0, 0,  0, 0, 0, 0, 0);
        row(1,  0,  0, 0, 0, 0,   0, 3, 0, 0, 0,  0, 0, 0, 0, 0);
        row(0,  0,  0, 0, 0, 0,   0, 3, 0, 0, 0,  0, 0, 0, 0, 0);
        // ADDI, R-type, SW, BNE stream
        row(0,  5,  1, 3, 0, 0,   0, 3, 0, 0, 0,  0, 0, 0, 0, 0);
        row(0,  1,  1, 2, 4, 0,   0, 0, 1, 0, 3,  0, 0, 0, 0, 0);
        row(0,  7,  1, 2, 0, 0,   0, 2, 0, 0, 4,  0, 0, 0, 0, 0);
        row(0, 10,  1, 2, 0, 0,   0, 0, 1, 0, 2,  0, 0, 1, 0, 3);
        row(0,  0,  0, 0, 0, 0,   0, 1, 0, 1, 2,  0, 1, 1, 0, 4);
        row(0,  0,  0, 0, 0, 0,   0, 3, 0, 0, 0,  0, 0, 0, 0, 2);
        row(0,  0,  0, 0, 0, 0,   0, 3, 0, 0, 0,  0, 0, 0, 0, 2);
        // LW r5 then R-type reading r5: one-cycle stall, R-type held in ID
        row(0,  6,  1, 5, 0, 0,   0, 3, 0, 0, 0,  0, 0, 0, 0, 0);
        row(0,  1,  5, 1, 8, 0,   1, 0, 1, 0, 5,  0, 0, 0, 0, 0);
        row(0,  1,  5, 1, 8, 0,   0, 3, 0, 0, 0,  1, 0, 0, 0, 0);
        row(0,  0,  0, 0, 0, 0,   0, 2, 0, 0, 8,  0, 0, 1, 1, 5);
        // LW r5 then R-type on r6/r7: independent, no stall
        row(0,  6,  1, 5, 0, 0,   0, 3, 0, 0, 0,  0, 0, 0, 0, 0);
        row(0,  1,  6, 7, 9, 0,   0, 0, 1, 0, 5,  0, 0, 1, 0, 8);
        // LW r0 then R-type reading r0: no stall
        row(0,  6,  1, 0, 0, 0,   0, 2, 0, 0, 9,  1, 0, 0, 0, 0);
        row(0,  1,  0, 0,10, 0,   0, 0, 1, 0, 0,  0, 0, 1, 1, 5);
        // LW r2 then LUI with Rs=2: LUI reads no register
        row(0,  6,  1, 2, 0, 0,   0, 2, 0, 0,10,  1, 0, 1, 0, 9);
        row(0,  4,  2, 3, 0, 0,   0, 0, 1, 0, 2,  0, 0, 1, 1, 0);
        // LW r6 then flushed BEQ reading r6: stall raised, flush wins, nothing survives
        row(0,  6,  1, 6, 0, 0,   0, 1, 1, 0, 3,  1, 0, 1, 0,10);
        row(0,  9,  6, 1, 0, 1,   1, 0, 1, 0, 6,  0, 0, 1, 1, 2);
        row(0,  0,  0, 0, 0, 0,   0, 3, 0, 0, 0,  1, 0, 1, 0, 3);
        row(0,  0,  0, 0, 0, 0,   0, 3, 0, 0, 0,  0, 0, 1, 1, 6);
        // undefined opcodes 11 and 63 decode as nop
        row(0, 11,  0, 0, 0, 0,   0, 3, 0, 0, 0,  0, 0, 0, 0, 0);
        row(0, 63,  0, 0, 0, 0,   0, 3, 0, 0, 0,  0, 0, 0, 0, 0);
        // fill MEM with SW and WB with LW, then reset mid-cycle clears them at once
        row(0,  6,  1,12, 0, 0,   0, 3, 0, 0, 0,  0, 0, 0, 0, 0);
        row(0,  7,  1,13, 0, 0,   0, 0, 1, 0,12,  0, 0, 0, 0, 0);
        row(0,  0,  0, 0, 0, 0,   0, 0, 1, 0,13,  1, 0, 0, 0, 0);
        row(1,  0,  0, 0, 0, 0,   0, 3, 0, 0, 0,  0, 0, 0, 0, 0);
        row(0,  0,  0, 0, 0, 0,   0, 3, 0, 0, 0,  0, 0, 0, 0, 0);
        row(0,  0,  0, 0, 0, 0,   0, 3, 0, 0, 0,  0, 0, 0, 0, 0);

        // Stimulus: drive one row per cycle just after the rising edge
        for (int i = 0; i < plan_s.size(); i++) begin
            @(posedge Clk);
            #1;
            Reset  = plan_s[i].rst;
            Opcode = plan_s[i].op;
            Rs     = plan_s[i].rs;
            Rt     = plan_s[i].rt;
            Rd     = plan_s[i].rd;
            Flush  = plan_s[i].fl;
            sb_q.push_back(plan_e[i]);
        end

        for (int k = 0; k < 5 && sb_q.size() != 0; k++) @(posedge Clk);
        @(posedge Clk);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d expected 0", sb_q.size());
        end
        if (mon_row != plan_e.size()) begin
            errors++;
            $display("FAIL rows_checked got %0d expected %0d", mon_row, plan_e.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
- Pipelined successor to the single-cycle main control decoder.
- Decodes the ID-stage opcode into a control bundle, then carries it through registered ID/EX, EX/MEM and MEM/WB stage registers.
- Adds load-use hazard detection (stall/bubble insertion), branch flush, and destination-register tracking.
- Sits between instruction fetch/decode and the datapath stage registers.

Parameters:
OPW, 6, opcode width; opcodes at or above 2^OPW are unreachable, and undefined values decode as nop.
REGW, 5, register-specifier width.
HAZARD_EN, 1, 1 enables load-use detection; 0 forces HazardStall=0.

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  asynchronous, active-high; clears all stage registers
Opcode  in  OPW  ID-stage instruction opcode
Rs  in  REGW  ID-stage source register 1
Rt  in  REGW  ID-stage source register 2 / I-type destination
Rd  in  REGW  ID-stage R-type destination
Flush  in  1  branch resolved taken; kill the ID-stage instruction
HazardStall  out  1  combinational; fetch/decode must hold PC and IF/ID
ExALUOp  out  2  EX stage: 0 add, 1 lui/bne, 2 funct decode, 3 nop
ExALUSrc  out  1  EX stage: immediate operand select
ExBranch  out  1  EX stage: branch/jump instruction
ExDest  out  REGW  EX-stage destination register (Rd if RegDst, else Rt)
MemRead  out  1  MEM stage: load
MemWrite  out  1  MEM stage: store
WbRegWrite  out  1  WB stage: register-file write enable
WbMemtoReg  out  1  WB stage: writeback selects memory data
WbDest  out  REGW  WB-stage destination register

Behaviour:
- Reset is asynchronous and active-high. All stage registers hold the nop bundle: ALUOp=3, every enable 0, Dest=0. Every registered output reads that bundle during reset and on the first edge after release.
- Decode (combinational, ID):
  - 0 = nop.
  - 1-3 = R-type: ALUOp 2, RegWrite, RegDst.
  - 4 = LUI: ALUOp 1, ALUSrc, RegWrite.
  - 5 = ADDI: ALUOp 0, ALUSrc, RegWrite.
  - 6 = LW: ALUOp 0, ALUSrc, MemRead, RegWrite, MemtoReg.
  - 7 = SW: ALUOp 0, ALUSrc, MemWrite.
  - 8 = JMP: Branch, ALUOp 0.
  - 9 = BEQ: Branch, ALUOp 0.
  - 10 = BNE: Branch, ALUOp 1.
  - 11 and above = nop.
- Operand use:
  - Uses Rs: every non-nop opcode except LUI.
  - Uses Rt: R-type, SW, BEQ, BNE.
- Latency: a decoded bundle appears on Ex* one edge after ID, on MemRead/MemWrite after two edges, and on Wb* after three edges.
- Hazard detection (combinational):
  - HazardStall = HAZARD_EN & EX.MemRead & EX.RegWrite & (ExDest≠0) & ((uses_rs & Rs==ExDest) | (uses_rt & Rt==ExDest)).
- Per-edge update of the EX register, in priority order:
  - Flush=1: load nop (flush has priority over stall).
  - Else HazardStall=1: load nop (bubble).
  - Else: load the decoded bundle.
- MEM and WB registers advance every cycle unconditionally; a stall never freezes downstream stages.
- A stall lasts exactly one cycle per load-use pair. After the bubble, EX holds a nop, so HazardStall deasserts.
- Destination: ExDest = RegDst ? Rd : Rt, captured with the bundle. Bubbles carry Dest=0.
- Register 0 as a destination never raises a hazard.
- Reset asserted mid-operation clears all three stages immediately, without waiting for a clock edge. In-flight instructions are dropped.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode localparams (OP_NOP … OP_BNE);
  - ALUOp encodings (ALU_ADD=0, ALU_LUI=1, ALU_FUNC=2, ALU_NOP=3);
  - the control-bundle struct type;
  - the constant NOP_BUNDLE.
- One sub-module, ctrl_decode: purely combinational opcode to bundle plus uses_rs/uses_rt. The top holds the three stage registers and the hazard logic.

Test Plan:
- Reset held then released, Opcode=0 → all outputs at the nop bundle (ExALUOp=3, all enables 0, dests 0); asserting Reset mid-stream clears MEM and WB before the next edge.
- Stream ADDI(Rt=3), R-type(Rd=4), SW, BNE → ExALUOp sequence 0, 2, 0, 1; WbRegWrite=1, 1, 0, 0 three cycles after each issue; WbDest=3, 4.
- LW (Rt=5) then R-type with Rs=5 → HazardStall=1 for exactly one cycle, one nop bubble in EX, R-type reaches EX one cycle late. Repeating with Rs=6, Rt=7 → no stall.
- LW (Rt=0) then R-type with Rs=0 → HazardStall stays 0. LW (Rt=2) then LUI with Rs=2 → no stall (LUI does not use Rs).
- Flush=1 with BEQ in ID while a load-use stall is pending → EX loads nop; nothing from the flushed instruction reaches MEM/WB.
- Opcodes 11 and 63, and HAZARD_EN=0 with a load-use pair → nop bundles for the undefined opcodes; HazardStall held at 0 with HAZARD_EN=0.
